// File: rtl/fb_pkg.sv
// Frame-buffer geometry, VGA constants and the fetch-state encoding shared by
// the arbiter and its address generator.
package fb_pkg;
  localparam int IMG_W    = 320;
  localparam int IMG_H    = 240;
  localparam int AW       = 17;
  localparam int DW       = 12;
  localparam int FB_DEPTH = IMG_W * IMG_H;
  localparam int HD       = 640;
  localparam int VD       = 480;
  localparam int CW       = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_LATCH = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fb_addr_gen.sv
// Maps a 640x480 VGA coordinate to its 2x-downscaled linear frame-buffer address
// and range-checks both that coordinate and a linear write address; combinational, no backpressure.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [CW-1:0] i_x,
  input  logic [CW-1:0] i_y,
  input  logic [AW-1:0] i_lin_addr,
  output logic [AW-1:0] o_addr,
  output logic          o_xy_ok,
  output logic          o_lin_ok
);
  logic [AW-1:0] w_row;
  logic [AW-1:0] w_col;

  assign w_row = AW'(i_y[CW-1:1]);
  assign w_col = AW'(i_x[CW-1:1]);

  // 320 = 256 + 64, so the row multiply reduces to two shifts and an add.
  if (IMG_W == 320) begin : g_shift
    assign o_addr = (w_row << 8) + (w_row << 6) + w_col;
  end else begin : g_mul
    assign o_addr = (w_row * AW'(IMG_W)) + w_col;
  end

  assign o_xy_ok  = (i_x < CW'(HD)) && (i_y < CW'(VD));
  assign o_lin_ok = (i_lin_addr < AW'(FB_DEPTH));
endmodule

// File: rtl/vga_frame_fetch_arbiter.sv
// Shares the frame-buffer port: one read per pixel tick (rgb 3 cycles after p_tick),
// writes granted in every non-read cycle; a write stalls at most 1 cycle behind a read.
module vga_frame_fetch_arbiter
  import fb_pkg::*;
(
  input  logic          clk_100MHz,
  input  logic          reset_n,
  input  logic          display_switch,
  input  logic          p_tick,
  input  logic          video_on,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rgb,
  output logic          frame_done,
  output logic          wr_err,
  output logic          tick_overrun
);
  fetch_state_t  r_state;
  logic [AW-1:0] r_rd_addr;
  logic          r_last;
  logic          r_run;
  logic [DW-1:0] r_rgb;
  logic          r_frame_done;
  logic          r_wr_err;
  logic          r_overrun;

  logic [AW-1:0] w_pix_addr;
  logic          w_xy_ok;
  logic          w_lin_ok;
  logic          w_rd;
  logic          w_grant;
  logic          w_wr_issue;

  fb_addr_gen u_addr_gen (
    .i_x        (x),
    .i_y        (y),
    .i_lin_addr (wr_addr),
    .o_addr     (w_pix_addr),
    .o_xy_ok    (w_xy_ok),
    .o_lin_ok   (w_lin_ok)
  );

  // r_run holds off grants for the first cycle out of reset so a request
  // held across reset is never acknowledged while reset is asserted.
  assign w_rd       = (r_state == S_READ);
  assign w_grant    = r_run && wr_req && !w_rd;
  assign w_wr_issue = w_grant && w_lin_ok;

  assign wr_ack    = w_grant;
  assign mem_en    = w_rd || w_wr_issue;
  assign mem_we    = w_wr_issue;
  assign mem_addr  = w_rd ? r_rd_addr : (w_wr_issue ? wr_addr : '0);
  assign mem_wdata = w_wr_issue ? wr_data : '0;

  assign rgb          = r_rgb;
  assign frame_done   = r_frame_done;
  assign wr_err       = r_wr_err;
  assign tick_overrun = r_overrun;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rd_addr    <= '0;
      r_last       <= 1'b0;
      r_run        <= 1'b0;
      r_rgb        <= '0;
      r_frame_done <= 1'b0;
      r_wr_err     <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_run        <= 1'b1;
      r_frame_done <= 1'b0;
      if (w_grant && !w_lin_ok) r_wr_err <= 1'b1;
      if (p_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (p_tick) begin
            r_rd_addr <= w_pix_addr;
            r_last    <= (x == CW'(HD - 1)) && (y == CW'(VD - 1));
            if (video_on && display_switch && w_xy_ok) r_state <= S_READ;
            else                                       r_rgb   <= '0;
          end
        end
        S_READ: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_rgb        <= mem_rdata;
          r_frame_done <= r_last;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_frame_fetch_arbiter.sv
// Directed and randomized checks of the frame-fetch arbiter against a pixel-level
// image model; includes a single-port BRAM with 1-cycle read latency.
module tb_vga_frame_fetch_arbiter;
  import fb_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          display_switch;
  logic          p_tick;
  logic          video_on;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rgb;
  logic          frame_done;
  logic          wr_err;
  logic          tick_overrun;

  int checks = 0;
  int errors = 0;

  vga_frame_fetch_arbiter dut (
    .clk_100MHz     (clk),
    .reset_n        (reset_n),
    .display_switch (display_switch),
    .p_tick         (p_tick),
    .video_on       (video_on),
    .x              (x),
    .y              (y),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .rgb            (rgb),
    .frame_done     (frame_done),
    .wr_err         (wr_err),
    .tick_overrun   (tick_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] init_pat(input int a);
    logic [31:0] t;
    t = a * 37 + 5;
    return t[11:0];
  endfunction

  // BRAM: unwritten locations return a fixed pattern.
  logic [DW-1:0] fb    [FB_DEPTH];
  bit            fb_wr [FB_DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        fb[mem_addr]    <= mem_wdata;
        fb_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= fb_wr[mem_addr] ? fb[mem_addr] : init_pat(int'(mem_addr));
      end
    end
  end

  // Expected image contents.
  logic [DW-1:0] ref_val [FB_DEPTH];
  bit            ref_set [FB_DEPTH];

  function automatic logic [11:0] ref_pix(input int a);
    return ref_set[a] ? ref_val[a] : init_pat(a);
  endfunction

  task automatic ref_write(input int a, input logic [11:0] d);
    ref_val[a] = d;
    ref_set[a] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [11:0] d, input bit ok);
    bit got;
    got = 1'b0;
    wr_req  = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (wr_ack === 1'b1) begin
        got = 1'b1;
        chk("wr_mem_en", mem_en, ok);
        chk("wr_mem_we", mem_we, ok);
        if (ok) begin
          chk("wr_mem_addr", mem_addr, a);
          chk("wr_mem_wdata", mem_wdata, d);
        end
      end
      step();
    end
    wr_req = 1'b0;
    chk("wr_acked", got, 1);
    if (ok && got) ref_write(a, d);
  endtask

  task automatic do_fetch(input int px, input int py, input bit vid, input bit disp);
    int a;
    bit en;
    logic [11:0] e;
    a  = (py / 2) * IMG_W + px / 2;
    en = vid && disp;
    e  = en ? ref_pix(a) : 12'h000;
    step();
    p_tick = 1'b1; x = CW'(px); y = CW'(py); video_on = vid; display_switch = disp;
    step();
    p_tick = 1'b0;
    @(negedge clk);
    chk("rd_mem_en", mem_en, en);
    if (en) begin
      chk("rd_mem_we", mem_we, 0);
      chk("rd_mem_addr", mem_addr, a);
    end
    step();
    step();
    @(negedge clk);
    chk("rgb", rgb, e);
    chk("frame_done", frame_done, en && px == HD - 1 && py == VD - 1);
    step();
    @(negedge clk);
    chk("frame_done_clear", frame_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int px;
    int py;
    logic [11:0] d;

    reset_n = 1'b0; display_switch = 1'b0; p_tick = 1'b0; video_on = 1'b0;
    x = '0; y = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_tick_overrun", tick_overrun, 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // Preload and fetch the top-left pixel.
    do_write(0, 12'hABC, 1);
    do_fetch(0, 0, 1, 1);

    // Bottom-right pixel: scaling and end-of-frame pulse.
    do_fetch(639, 479, 1, 1);

    // Write held into the read cycle waits exactly one cycle.
    step();
    p_tick = 1'b1; x = '0; y = '0; video_on = 1'b1; display_switch = 1'b1;
    step();
    p_tick = 1'b0; wr_req = 1'b1; wr_addr = AW'(5); wr_data = 12'h123;
    @(negedge clk);
    chk("col_read_we", mem_we, 0);
    chk("col_read_addr", mem_addr, 0);
    chk("col_no_ack", wr_ack, 0);
    step();
    @(negedge clk);
    chk("col_ack", wr_ack, 1);
    chk("col_we", mem_we, 1);
    chk("col_addr", mem_addr, 5);
    chk("col_wdata", mem_wdata, 12'h123);
    step();
    wr_req = 1'b0;
    ref_write(5, 12'h123);
    @(negedge clk);
    chk("col_ack_drop", wr_ack, 0);
    chk("col_rgb", rgb, ref_pix(0));
    do_fetch(10, 1, 1, 1);

    // Out-of-range write is acked, not issued, and flagged.
    chk("wr_err_pre", wr_err, 0);
    do_write(FB_DEPTH, 12'h5A5, 0);
    @(negedge clk);
    chk("wr_err_set", wr_err, 1);

    // Blanking: every cycle goes to the writer.
    for (int i = 0; i < 16; i++) begin
      step();
      p_tick = (i % 4 == 0); x = CW'(i * 8); y = CW'(10); video_on = 1'b0; display_switch = 1'b1;
      wr_req = 1'b1; wr_addr = AW'(3000 + i); wr_data = 12'(i * 5 + 1);
      @(negedge clk);
      chk("blank_ack", wr_ack, 1);
      chk("blank_we", mem_we, 1);
      chk("blank_addr", mem_addr, 3000 + i);
      ref_write(3000 + i, 12'(i * 5 + 1));
    end
    step();
    wr_req = 1'b0; p_tick = 1'b0;
    @(negedge clk);
    chk("blank_rgb", rgb, 0);
    a = 3005;
    do_fetch(2 * (a % IMG_W), 2 * (a / IMG_W) + 1, 1, 1);

    // Display off: same, with video_on high.
    for (int i = 0; i < 16; i++) begin
      step();
      p_tick = (i % 4 == 0); x = CW'(i * 8); y = CW'(20); video_on = 1'b1; display_switch = 1'b0;
      wr_req = 1'b1; wr_addr = AW'(3100 + i); wr_data = 12'(i * 9 + 2);
      @(negedge clk);
      chk("dispoff_ack", wr_ack, 1);
      chk("dispoff_we", mem_we, 1);
      chk("dispoff_addr", mem_addr, 3100 + i);
      ref_write(3100 + i, 12'(i * 9 + 2));
    end
    step();
    wr_req = 1'b0; p_tick = 1'b0;
    @(negedge clk);
    chk("dispoff_rgb", rgb, 0);
    chk("wr_err_sticky", wr_err, 1);
    a = 3111;
    do_fetch(2 * (a % IMG_W) + 1, 2 * (a / IMG_W), 1, 1);

    // Randomized writes, read-backs and fetches.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = $urandom_range(0, FB_DEPTH - 1);
        d = 12'($urandom);
        do_write(a, d, 1);
        do_fetch(2 * (a % IMG_W) + $urandom_range(0, 1), 2 * (a / IMG_W) + $urandom_range(0, 1), 1, 1);
      end else begin
        px = $urandom_range(0, HD - 1);
        py = $urandom_range(0, VD - 1);
        do_fetch(px, py, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end
    end

    // Second tick during a fetch: flagged, first fetch still lands.
    chk("overrun_pre", tick_overrun, 0);
    step();
    p_tick = 1'b1; x = CW'(100); y = CW'(50); video_on = 1'b1; display_switch = 1'b1;
    step();
    x = CW'(300); y = CW'(300);
    @(negedge clk);
    chk("overrun_read_addr", mem_addr, 25 * IMG_W + 50);
    step();
    p_tick = 1'b0;
    step();
    @(negedge clk);
    chk("overrun_rgb", rgb, ref_pix(25 * IMG_W + 50));
    chk("overrun_flag", tick_overrun, 1);

    // Reset in the read cycle of a fetch, with a write pending across it.
    do_fetch(1, 1, 1, 1);
    step();
    p_tick = 1'b1; x = CW'(200); y = CW'(100); video_on = 1'b1; display_switch = 1'b1;
    step();
    p_tick = 1'b0; wr_req = 1'b1; wr_addr = AW'(77); wr_data = 12'h3C3; reset_n = 1'b0;
    #1;
    chk("midrst_rgb", rgb, 0);
    chk("midrst_wr_ack", wr_ack, 0);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_wr_err", wr_err, 0);
    chk("midrst_overrun", tick_overrun, 0);
    step();
    @(negedge clk);
    chk("midrst_hold_ack", wr_ack, 0);
    step();
    reset_n = 1'b1;
    do_write(77, 12'h3C3, 1);
    step(); step();
    @(negedge clk);
    chk("postrst_rgb", rgb, 0);
    chk("postrst_mem_en", mem_en, 0);
    do_fetch(154, 1, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
